// File: rtl/bram_frame_streamer.sv
// bram_frame_streamer
// Stores one raster-order frame in KERNEL_WIDTH identical block-RAM copies and
// streams it back as vertical pixel columns, one lane per kernel row.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous reset, active low
//   i_start_loading     pulse: begin loading a new frame (IDLE/READY only)
//   i_valid_data        i_data_to_mem is valid (LOAD only)
//   i_data_to_mem       pixel, raster order
//   i_start_processing  pulse: stream the stored frame (READY only)
//   i_ready             downstream accepts the current beat
//   o_valid             o_to_conv holds a beat
//   o_to_conv           lane k at [k*RAM_WIDTH +: RAM_WIDTH]
//   o_is_frame_ready    a complete frame is stored
//   o_busy              loading or streaming
//   o_frame_done        one-cycle pulse after the last beat is accepted
//
// state   | meaning
// IDLE    | no valid frame stored
// LOAD    | writing pixels, address advances per i_valid_data
// READY   | complete frame stored, waiting for a stream request
// PROCESS | streaming beats to the convolver
module bram_frame_streamer #(
  parameter int    RAM_WIDTH    = 8,
  parameter int    IMAGE_WIDTH  = 10,
  parameter int    IMAGE_HEIGHT = 10,
  parameter int    KERNEL_WIDTH = 3,
  parameter int    PAD_MODE     = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_start_loading,
  input  logic                              i_valid_data,
  input  logic [RAM_WIDTH-1:0]              i_data_to_mem,
  input  logic                              i_start_processing,
  input  logic                              i_ready,
  output logic                              o_valid,
  output logic [KERNEL_WIDTH*RAM_WIDTH-1:0] o_to_conv,
  output logic                              o_is_frame_ready,
  output logic                              o_busy,
  output logic                              o_frame_done
);

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEPTH  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int AW     = (clogb2(DEPTH - 1) < 1) ? 1 : clogb2(DEPTH - 1);
  localparam int OFF    = (PAD_MODE != 0) ? (KERNEL_WIDTH - 1) / 2 : 0;
  localparam int GROUPS = (PAD_MODE != 0) ? IMAGE_HEIGHT : IMAGE_HEIGHT - KERNEL_WIDTH + 1;
  localparam int GW     = $clog2(IMAGE_HEIGHT + 1);
  localparam int CW     = $clog2(IMAGE_WIDTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;
  localparam logic [1:0] S_PROCESS = 2'd3;

  logic [1:0]              r_state;
  logic [AW-1:0]           r_waddr;
  logic                    r_frame_ready;
  logic                    r_frame_done;
  logic [GW-1:0]           r_g;
  logic [CW-1:0]           r_c;
  logic                    r_issue_done;

  // Two-stage read pipeline: stage 1 holds the registered read address,
  // stage 2 is the RAM output register that drives o_to_conv.
  logic                    r_v1, r_v2;
  logic                    r_last1, r_last2;
  logic [KERNEL_WIDTH-1:0] r_zero1, r_zero2;
  logic [AW-1:0]           r_addr [KERNEL_WIDTH];

  logic [KERNEL_WIDTH-1:0] w_zero;
  logic [AW-1:0]           w_addr [KERNEL_WIDTH];
  logic                    w_issue;
  logic                    w_adv;
  logic                    w_last_issue;
  logic                    w_accept_last;
  logic                    w_we;
  logic                    w_rd_en;

  // Lane k of beat (g,c) reads row g+k-OFF; rows off the frame become zeros.
  always_comb begin : p_addr
    int row;
    for (int k = 0; k < KERNEL_WIDTH; k++) begin
      row       = int'(r_g) + k - OFF;
      w_zero[k] = 1'b0;
      w_addr[k] = '0;
      if (row < 0 || row >= IMAGE_HEIGHT) w_zero[k] = 1'b1;
      else w_addr[k] = AW'(row * IMAGE_WIDTH + int'(r_c));
    end
  end

  assign w_last_issue  = (r_g == GW'(GROUPS - 1)) && (r_c == CW'(IMAGE_WIDTH - 1));
  assign w_issue       = (r_state == S_PROCESS) && !r_issue_done;
  // The whole pipeline moves only when the output slot is empty or being taken.
  assign w_adv         = !r_v2 || i_ready;
  assign w_accept_last = r_v2 && i_ready && r_last2;
  assign w_we          = (r_state == S_LOAD) && i_valid_data;
  assign w_rd_en       = (r_state == S_PROCESS) && w_adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_waddr       <= '0;
      r_frame_ready <= 1'b0;
      r_frame_done  <= 1'b0;
      r_g           <= '0;
      r_c           <= '0;
      r_issue_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_loading) begin
            r_state <= S_LOAD;
            r_waddr <= '0;
          end
        end
        S_LOAD: begin
          if (i_valid_data) begin
            r_waddr <= r_waddr + 1'b1;
            if (r_waddr == AW'(DEPTH - 1)) begin
              r_state       <= S_READY;
              r_frame_ready <= 1'b1;
            end
          end
        end
        S_READY: begin
          if (i_start_loading) begin
            r_state       <= S_LOAD;
            r_waddr       <= '0;
            r_frame_ready <= 1'b0;
          end else if (i_start_processing) begin
            r_state      <= S_PROCESS;
            r_g          <= '0;
            r_c          <= '0;
            r_issue_done <= 1'b0;
          end
        end
        default: begin
          if (w_issue && w_adv) begin
            if (w_last_issue) begin
              r_issue_done <= 1'b1;
            end else if (r_c == CW'(IMAGE_WIDTH - 1)) begin
              r_c <= '0;
              r_g <= r_g + 1'b1;
            end else begin
              r_c <= r_c + 1'b1;
            end
          end
          if (w_accept_last) begin
            r_state      <= S_READY;
            r_frame_done <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_last1 <= 1'b0;
      r_last2 <= 1'b0;
      r_zero1 <= '0;
      r_zero2 <= '0;
      for (int k = 0; k < KERNEL_WIDTH; k++) r_addr[k] <= '0;
    end else if (r_state != S_PROCESS) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_last1 <= 1'b0;
      r_last2 <= 1'b0;
    end else if (w_adv) begin
      r_v1    <= w_issue;
      r_last1 <= w_issue && w_last_issue;
      r_zero1 <= w_zero;
      r_addr  <= w_addr;
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      r_zero2 <= r_zero1;
    end
  end

  for (genvar k = 0; k < KERNEL_WIDTH; k++) begin : g_copy
    logic [RAM_WIDTH-1:0] r_mem [DEPTH];
    logic [RAM_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
      if (w_we) r_mem[r_waddr] <= i_data_to_mem;
      if (w_rd_en) r_rd_data <= r_mem[r_addr[k]];
    end

    assign o_to_conv[k*RAM_WIDTH +: RAM_WIDTH] = (r_v2 && !r_zero2[k]) ? r_rd_data : '0;
  end

  assign o_valid          = r_v2;
  assign o_is_frame_ready = r_frame_ready;
  assign o_busy           = (r_state == S_LOAD) || (r_state == S_PROCESS);
  assign o_frame_done     = r_frame_done;

endmodule

// File: tb/tb_bram_frame_streamer.sv
// tb_bram_frame_streamer
// Drives one valid-rows streamer and one zero-padded streamer from the same
// inputs and compares every presented beat against a frame model.
module tb_bram_frame_streamer;
  localparam int RW    = 8;
  localparam int W     = 10;
  localparam int H     = 10;
  localparam int K     = 3;
  localparam int DEPTH = W * H;
  localparam int TOT0  = (H - K + 1) * W;
  localparam int TOT1  = H * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_start_loading = 1'b0;
  logic          i_valid_data = 1'b0;
  logic [RW-1:0] i_data_to_mem = '0;
  logic          i_start_processing = 1'b0;
  logic          i_ready = 1'b0;

  logic          v0, v1, fr0, fr1, busy0, busy1, done0, done1;
  logic [K*RW-1:0] d0, d1;

  bram_frame_streamer #(.RAM_WIDTH(RW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
                        .KERNEL_WIDTH(K), .PAD_MODE(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .reset(reset), .i_start_loading(i_start_loading),
    .i_valid_data(i_valid_data), .i_data_to_mem(i_data_to_mem),
    .i_start_processing(i_start_processing), .i_ready(i_ready),
    .o_valid(v0), .o_to_conv(d0), .o_is_frame_ready(fr0), .o_busy(busy0),
    .o_frame_done(done0));

  bram_frame_streamer #(.RAM_WIDTH(RW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
                        .KERNEL_WIDTH(K), .PAD_MODE(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .reset(reset), .i_start_loading(i_start_loading),
    .i_valid_data(i_valid_data), .i_data_to_mem(i_data_to_mem),
    .i_start_processing(i_start_processing), .i_ready(i_ready),
    .o_valid(v1), .o_to_conv(d1), .o_is_frame_ready(fr1), .o_busy(busy1),
    .o_frame_done(done1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frame [DEPTH];
  int n0, n1, bub0, bub1;
  bit mon_en = 1'b0;
  bit pend0, pend1, stl0, stl1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat n of a stream: group n/W, column n%W, lane k from row g+k-offset.
  function automatic logic [K*RW-1:0] exp_beat(input int mode, input int n);
    logic [K*RW-1:0] b;
    int g, c, r;
    b = '0;
    g = n / W;
    c = n % W;
    for (int k = 0; k < K; k++) begin
      r = g + k - ((mode != 0) ? (K - 1) / 2 : 0);
      if (r >= 0 && r < H) b[k*RW +: RW] = RW'(frame[r*W + c]);
    end
    return b;
  endfunction

  always @(negedge clk) begin
    bit e0, e1;
    if (mon_en) begin
      e0 = pend0; pend0 = 1'b0;
      e1 = pend1; pend1 = 1'b0;
      check("done0", done0, e0);
      check("done1", done1, e1);
      if (e0) check("vlow0", v0, 0);
      if (e1) check("vlow1", v1, 0);
      if (stl0) check("hold0", v0, 1);
      if (stl1) check("hold1", v1, 1);
      stl0 = v0 && !i_ready;
      stl1 = v1 && !i_ready;
      if (v0) begin
        if (n0 < TOT0) check("beat0", d0, exp_beat(0, n0));
        else check("extra0", v0, 0);
        if (i_ready) begin n0++; if (n0 == TOT0) pend0 = 1'b1; end
      end else if (n0 > 0 && n0 < TOT0) bub0++;
      if (v1) begin
        if (n1 < TOT1) check("beat1", d1, exp_beat(1, n1));
        else check("extra1", v1, 0);
        if (i_ready) begin n1++; if (n1 == TOT1) pend1 = 1'b1; end
      end else if (n1 > 0 && n1 < TOT1) bub1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input bit addr_pat, input bit gaps);
    for (int p = 0; p < DEPTH; p++) frame[p] = addr_pat ? p : int'($urandom_range(0, 255));
    i_start_loading = 1'b1;
    tick();
    i_start_loading = 1'b0;
    check("ld_fr_drop0", fr0, 0);
    check("ld_fr_drop1", fr1, 0);
    for (int p = 0; p < DEPTH; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_valid_data = 1'b0;
        tick();
      end
      i_valid_data  = 1'b1;
      i_data_to_mem = RW'(frame[p]);
      check("ld_busy0", busy0, 1);
      check("ld_busy1", busy1, 1);
      tick();
      if (p == DEPTH - 1) begin
        check("ld_ready0", fr0, 1);
        check("ld_ready1", fr1, 1);
        check("ld_idle0", busy0, 0);
      end else if (p % 25 == 0) begin
        check("ld_notready0", fr0, 0);
      end
    end
    i_valid_data = 1'b0;
  endtask

  // rmode 0: ready held high, 1: five-cycle stall at beat 7, 2: random ready
  task automatic process(input int rmode, input bit do_reset, input bit inject, input bit addr_pat);
    int  stall_cnt;
    bit  was_reset;
    stall_cnt = 0;
    was_reset = 1'b0;
    n0 = 0; n1 = 0; bub0 = 0; bub1 = 0;
    pend0 = 1'b0; pend1 = 1'b0; stl0 = 1'b0; stl1 = 1'b0;
    i_ready = 1'b1;
    mon_en  = 1'b1;
    i_start_processing = 1'b1;
    tick();
    i_start_processing = 1'b0;
    check("lat0_v0", v0, 0);
    check("pr_busy0", busy0, 1);
    tick();
    check("lat1_v0", v0, 0);
    check("lat1_v1", v1, 0);
    tick();
    check("lat2_v0", v0, 1);
    check("lat2_v1", v1, 1);
    if (addr_pat) begin
      check("first0", d0, 24'h140A00);
      check("first1", d1, 24'h0A0000);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (n0 >= TOT0 && n1 >= TOT1 && !pend0 && !pend1) break;
      case (rmode)
        0: i_ready = 1'b1;
        1: begin
          if (n0 == 7 && stall_cnt < 5) begin i_ready = 1'b0; stall_cnt++; end
          else i_ready = 1'b1;
        end
        default: i_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (inject && n0 >= 20 && n0 < 25) begin
        i_start_loading = 1'b1;
        i_valid_data    = 1'b1;
        i_data_to_mem   = RW'($urandom_range(0, 255));
      end else begin
        i_start_loading = 1'b0;
        i_valid_data    = 1'b0;
      end
      if (do_reset && n0 == 40) begin
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("rst_v0", v0, 0);   check("rst_v1", v1, 0);
        check("rst_d0", d0, 0);   check("rst_d1", d1, 0);
        check("rst_fr0", fr0, 0); check("rst_fr1", fr1, 0);
        check("rst_bz0", busy0, 0); check("rst_dn0", done0, 0);
        was_reset = 1'b1;
        break;
      end
      tick();
    end
    i_ready = 1'b1;
    i_start_loading = 1'b0;
    i_valid_data = 1'b0;
    if (was_reset) begin
      #2 reset = 1'b1;
      tick();
      i_start_processing = 1'b1;
      tick();
      i_start_processing = 1'b0;
      repeat (4) tick();
      check("norun_v0", v0, 0);  check("norun_v1", v1, 0);
      check("norun_bz0", busy0, 0);
      check("norun_fr0", fr0, 0);
    end else begin
      mon_en = 1'b0;
      check("count0", n0, TOT0);
      check("count1", n1, TOT1);
      check("end_fr0", fr0, 1);  check("end_fr1", fr1, 1);
      check("end_bz0", busy0, 0); check("end_bz1", busy1, 0);
      check("end_v0", v0, 0);
      if (rmode == 0) begin
        check("bubbles0", bub0, 0);
        check("bubbles1", bub1, 0);
      end
    end
    mon_en = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("init_v0", v0, 0);   check("init_v1", v1, 0);
    check("init_d0", d0, 0);   check("init_fr0", fr0, 0);
    check("init_bz0", busy0, 0); check("init_dn0", done0, 0);
    reset = 1'b1;
    tick();

    i_start_processing = 1'b1;
    tick();
    i_start_processing = 1'b0;
    repeat (3) tick();
    check("idle_v0", v0, 0);
    check("idle_bz0", busy0, 0);

    load_frame(1'b1, 1'b0);
    process(0, 1'b0, 1'b0, 1'b1);
    process(1, 1'b0, 1'b0, 1'b0);

    i_valid_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data_to_mem = RW'($urandom_range(0, 255));
      tick();
    end
    i_valid_data = 1'b0;
    check("rdy_stay0", fr0, 1);
    process(2, 1'b0, 1'b1, 1'b0);

    load_frame(1'b0, 1'b1);
    process(2, 1'b1, 1'b0, 1'b0);

    load_frame(1'b0, 1'b1);
    process(2, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
